// File: rtl/mps_xintf_pkg.sv
// Shared XINTF mailbox definitions: bridge FSM states and the doorbell/status map
// also used by the DSP Handler (Zynq->DSP words 8..47, DSP->Zynq words 128..176).
package mps_xintf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_EXEC,
        ST_R_FETCH,
        ST_R_WAIT,
        ST_R_DRIVE,
        ST_R_HOLD
    } xintf_state_e;

    localparam logic [8:0] XINTF_RD_DONE_ADDR = 9'd0;
    localparam logic [8:0] XINTF_STATUS_ADDR  = 9'd1;
    localparam logic [8:0] XINTF_WR_DONE_ADDR = 9'd127;
    localparam logic [8:0] XINTF_DSP_WR_BASE  = 9'd128;

endpackage

// File: rtl/xintf_strobe_sync.sv
// Two-flop synchronisers and edge detection for the XINTF CS/WE/RD strobes.
module xintf_strobe_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cs_n,
    input  logic i_we_n,
    input  logic i_rd_n,
    output logic o_cs_n_s,
    output logic o_we_fall,
    output logic o_rd_fall,
    output logic o_rd_rise,
    output logic o_cs_rise
);

    // bit order {rd, we, cs}
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [2:0] prev_q;
    logic [1:0] arm_q;

    // Sync flops reset to "asserted" and arming needs a seen-high level, so a strobe
    // still held low across reset cannot produce a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '1;
            arm_q  <= '0;
        end else begin
            meta_q <= {i_rd_n, i_we_n, i_cs_n};
            sync_q <= meta_q;
            prev_q <= sync_q;
            arm_q  <= arm_q | sync_q[2:1];
        end
    end

    assign o_cs_n_s  = sync_q[0];
    assign o_we_fall = arm_q[0] & prev_q[1] & ~sync_q[1];
    assign o_rd_fall = arm_q[1] & prev_q[2] & ~sync_q[2];
    assign o_rd_rise = ~prev_q[2] & sync_q[2];
    assign o_cs_rise = ~prev_q[0] & sync_q[0];

endmodule

// File: rtl/dsp_xintf_bridge.sv
// DSP-side XINTF bridge onto BRAM port B with doorbells, status word and link timeout.
//   state    | meaning
//   IDLE     | wait for a synced WE/RD falling edge with CS low
//   W_EXEC   | one-cycle decode: doorbell, BRAM write or protection error
//   R_FETCH  | BRAM port-B read issued
//   R_WAIT   | BRAM latency; read data / status latched to the pad register
//   R_DRIVE  | data bus driven
//   R_HOLD   | keep driving until RD or CS rises
module dsp_xintf_bridge
    import mps_xintf_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 9,
    parameter int unsigned       DATA_W       = 16,
    parameter logic [ADDR_W-1:0] RD_DONE_ADDR = XINTF_RD_DONE_ADDR,
    parameter logic [ADDR_W-1:0] WR_DONE_ADDR = XINTF_WR_DONE_ADDR,
    parameter logic [ADDR_W-1:0] STATUS_ADDR  = XINTF_STATUS_ADDR,
    parameter logic [ADDR_W-1:0] DSP_WR_BASE  = XINTF_DSP_WR_BASE,
    parameter logic [31:0]       TIMEOUT_CYC  = 32'd1_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_xintf_cs_n,
    input  logic              i_xintf_we_n,
    input  logic              i_xintf_rd_n,
    input  logic [ADDR_W-1:0] i_xintf_addr,
    input  logic [DATA_W-1:0] i_xintf_din,
    output logic [DATA_W-1:0] o_xintf_dout,
    output logic              o_xintf_oe,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_bram_din,
    output logic              o_bram_en,
    output logic              o_bram_we,
    input  logic [DATA_W-1:0] i_bram_dout,
    input  logic              i_w_valid,
    output logic              o_w_ready,
    output logic              o_r_valid,
    output logic              o_wr_err,
    output logic              o_link_timeout
);

    logic cs_n_s, we_fall, rd_fall, rd_rise, cs_rise;

    xintf_strobe_sync u_sync (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cs_n    (i_xintf_cs_n),
        .i_we_n    (i_xintf_we_n),
        .i_rd_n    (i_xintf_rd_n),
        .o_cs_n_s  (cs_n_s),
        .o_we_fall (we_fall),
        .o_rd_fall (rd_fall),
        .o_rd_rise (rd_rise),
        .o_cs_rise (cs_rise)
    );

    xintf_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              wr_err_q, wr_err_d;
    logic              status_q, status_d;
    logic              wvalid_prev_q;
    logic [31:0]       tmo_q, tmo_d;
    logic              rd_done, wr_done;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        wr_err_d    = wr_err_q;
        rd_done     = 1'b0;
        wr_done     = 1'b0;
        o_bram_addr = '0;
        o_bram_din  = '0;
        o_bram_en   = 1'b0;
        o_bram_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (we_fall && !cs_n_s) begin
                    state_d = ST_W_EXEC;
                    addr_d  = i_xintf_addr;
                    din_d   = i_xintf_din;
                end else if (rd_fall && !cs_n_s) begin
                    state_d = ST_R_FETCH;
                    addr_d  = i_xintf_addr;
                end
            end
            ST_W_EXEC: begin
                state_d = ST_IDLE;
                if (addr_q == RD_DONE_ADDR) begin
                    rd_done = 1'b1;
                end else if (addr_q == WR_DONE_ADDR) begin
                    wr_done = 1'b1;
                end else if (addr_q >= DSP_WR_BASE) begin
                    o_bram_en   = 1'b1;
                    o_bram_we   = 1'b1;
                    o_bram_addr = addr_q;
                    o_bram_din  = din_q;
                end else begin
                    wr_err_d = 1'b1;
                end
            end
            ST_R_FETCH: begin
                o_bram_en   = 1'b1;
                o_bram_addr = addr_q;
                state_d     = ST_R_WAIT;
            end
            ST_R_WAIT: begin
                // pad data is registered so the bus sees a clean value from R_DRIVE on
                state_d = ST_R_DRIVE;
                oe_d    = 1'b1;
                dout_d  = (addr_q == STATUS_ADDR) ? {{(DATA_W-1){1'b0}}, status_q} : i_bram_dout;
            end
            ST_R_DRIVE, ST_R_HOLD: begin
                if (rd_rise || cs_rise) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end else begin
                    state_d = ST_R_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end

    assign o_w_ready = rd_done;
    assign o_r_valid = wr_done;

    always_comb begin
        status_d = status_q;
        if (i_w_valid && !wvalid_prev_q) begin
            status_d = 1'b1;
        end else if (rd_done) begin
            status_d = 1'b0;
        end

        tmo_d = tmo_q;
        if (rd_done || wr_done) begin
            tmo_d = '0;
        end else if (tmo_q != TIMEOUT_CYC) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            din_q         <= '0;
            dout_q        <= '0;
            oe_q          <= 1'b0;
            wr_err_q      <= 1'b0;
            status_q      <= 1'b0;
            wvalid_prev_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            dout_q        <= dout_d;
            oe_q          <= oe_d;
            wr_err_q      <= wr_err_d;
            status_q      <= status_d;
            wvalid_prev_q <= i_w_valid;
            tmo_q         <= tmo_d;
        end
    end

    assign o_xintf_dout   = dout_q;
    assign o_xintf_oe     = oe_q;
    assign o_wr_err       = wr_err_q;
    assign o_link_timeout = (tmo_q == TIMEOUT_CYC);

endmodule

// File: tb/tb_dsp_xintf_bridge.sv
// Directed bench for dsp_xintf_bridge with a 1-cycle-latency BRAM model on port B.
module tb_dsp_xintf_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1, we_n = 1'b1, rd_n = 1'b1;
    logic [8:0]  xaddr = '0;
    logic [15:0] xdin = '0;
    logic [15:0] xdout;
    logic        oe;
    logic [8:0]  bram_addr;
    logic [15:0] bram_din, bram_dout;
    logic        bram_en, bram_we;
    logic        w_valid = 1'b0;
    logic        w_ready, r_valid, wr_err, link_timeout;

    always #5 clk = ~clk;

    dsp_xintf_bridge #(.TIMEOUT_CYC(32'd100)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_xintf_cs_n   (cs_n),
        .i_xintf_we_n   (we_n),
        .i_xintf_rd_n   (rd_n),
        .i_xintf_addr   (xaddr),
        .i_xintf_din    (xdin),
        .o_xintf_dout   (xdout),
        .o_xintf_oe     (oe),
        .o_bram_addr    (bram_addr),
        .o_bram_din     (bram_din),
        .o_bram_en      (bram_en),
        .o_bram_we      (bram_we),
        .i_bram_dout    (bram_dout),
        .i_w_valid      (w_valid),
        .o_w_ready      (w_ready),
        .o_r_valid      (r_valid),
        .o_wr_err       (wr_err),
        .o_link_timeout (link_timeout)
    );

    logic [15:0] mem [0:511];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'h0000;
            mem[44] <= 16'h5A5A;
        end else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout <= mem[bram_addr];
        end
    end

    int          cyc, we_cnt, fetch_cnt, wready_cnt, rvalid_cnt, oe_cnt, viol_cnt, db_cyc, to_cyc;
    logic        to_prev = 1'b0;
    logic [8:0]  last_wa;
    logic [15:0] last_wd;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bram_en && bram_we) begin
            we_cnt  <= we_cnt + 1;
            last_wa <= bram_addr;
            last_wd <= bram_din;
        end
        if (bram_en && !bram_we) fetch_cnt <= fetch_cnt + 1;
        if (w_ready) wready_cnt <= wready_cnt + 1;
        if (r_valid) rvalid_cnt <= rvalid_cnt + 1;
        if (w_ready || r_valid) db_cyc <= cyc;
        if (link_timeout && !to_prev) to_cyc <= cyc;
        to_prev <= link_timeout;
        if (oe) oe_cnt <= oe_cnt + 1;
        if (bram_we && (oe || !bram_en)) viol_cnt <= viol_cnt + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xwrite(input logic [8:0] a, input logic [15:0] d);
        xaddr = a; xdin = d; cs_n = 1'b0;
        step(1);
        we_n = 1'b0;
        step(6);
        we_n = 1'b1;
        step(1);
        cs_n = 1'b1;
        step(4);
    endtask

    // lat: rising edges from rd_n fall to oe seen; drop: edges from rd_n rise to oe low
    task automatic wait_oe(output int lat, output logic [15:0] d);
        lat = 99; d = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); @(negedge clk);
            if (oe) begin lat = i; d = xdout; break; end
        end
    endtask

    task automatic xread(input logic [8:0] a, output logic [15:0] d, output int lat, output int drop);
        xaddr = a; cs_n = 1'b0;
        step(1);
        rd_n = 1'b0;
        wait_oe(lat, d);
        step(3);
        rd_n = 1'b1;
        drop = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (!oe) begin drop = i; break; end
        end
        step(1);
        cs_n = 1'b1;
        step(4);
    endtask

    typedef struct {
        logic        wr;
        logic [8:0]  addr;
        logic [15:0] data;
        int          exp_we;
        int          exp_wready;
        int          exp_rvalid;
        logic        exp_err;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    initial begin
        logic [15:0] rdat;
        int lat, drop, we0, f0, wr0, rv0, oe0, lat_ok;

        tbl[0]  = '{1'b1, 9'd130, 16'h1234, 1, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 9'd20,  16'hBEEF, 0, 0, 0, 1'b1};
        tbl[2]  = '{1'b0, 9'd44,  16'h5A5A, 0, 0, 0, 1'b1};
        tbl[3]  = '{1'b1, 9'd200, 16'hCAFE, 1, 0, 0, 1'b1};
        tbl[4]  = '{1'b0, 9'd200, 16'hCAFE, 0, 0, 0, 1'b1};
        tbl[5]  = '{1'b0, 9'd130, 16'h1234, 0, 0, 0, 1'b1};
        tbl[6]  = '{1'b0, 9'd1,   16'h0000, 0, 0, 0, 1'b1};
        tbl[7]  = '{1'b1, 9'd127, 16'h4444, 0, 0, 1, 1'b1};
        tbl[8]  = '{1'b1, 9'd0,   16'h5555, 0, 1, 0, 1'b1};
        tbl[9]  = '{1'b1, 9'd128, 16'h0080, 1, 0, 0, 1'b1};
        tbl[10] = '{1'b0, 9'd128, 16'h0080, 0, 0, 0, 1'b1};
        tbl[11] = '{1'b1, 9'd126, 16'h7777, 0, 0, 0, 1'b1};

        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_oe", oe, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_timeout", link_timeout, 0);
        chk("rst_doorbells", {w_ready, r_valid}, 0);
        step(4);

        for (int i = 0; i < NV; i++) begin
            we0 = we_cnt; wr0 = wready_cnt; rv0 = rvalid_cnt;
            if (tbl[i].wr) begin
                xwrite(tbl[i].addr, tbl[i].data);
                if (tbl[i].exp_we != 0) begin
                    chk($sformatf("v%0d_waddr", i), last_wa, tbl[i].addr);
                    chk($sformatf("v%0d_wdata", i), last_wd, tbl[i].data);
                end
            end else begin
                xread(tbl[i].addr, rdat, lat, drop);
                chk($sformatf("v%0d_rdata", i), rdat, tbl[i].data);
                chk($sformatf("v%0d_rd_latency", i), lat, 5);
                lat_ok = (drop >= 2 && drop <= 3) ? 1 : 0;
                chk($sformatf("v%0d_oe_drop_2to3=%0d", i, drop), lat_ok, 1);
            end
            chk($sformatf("v%0d_we_count", i), we_cnt - we0, tbl[i].exp_we);
            chk($sformatf("v%0d_w_ready_count", i), wready_cnt - wr0, tbl[i].exp_wready);
            chk($sformatf("v%0d_r_valid_count", i), rvalid_cnt - rv0, tbl[i].exp_rvalid);
            chk($sformatf("v%0d_wr_err", i), wr_err, tbl[i].exp_err);
        end

        // status flag: set by w_valid rise, cleared by RD_DONE doorbell
        w_valid = 1'b1;
        step(2);
        xread(9'd1, rdat, lat, drop);
        chk("status_set", rdat, 16'h0001);
        wr0 = wready_cnt;
        xwrite(9'd0, 16'h0000);
        chk("rd_done_pulse", wready_cnt - wr0, 1);
        xread(9'd1, rdat, lat, drop);
        chk("status_clr", rdat, 16'h0000);
        w_valid = 1'b0;

        // write and read falling together: write wins, read dropped
        we0 = we_cnt; f0 = fetch_cnt; oe0 = oe_cnt;
        xaddr = 9'd140; xdin = 16'h1111; cs_n = 1'b0;
        step(1);
        we_n = 1'b0; rd_n = 1'b0;
        step(6);
        we_n = 1'b1; rd_n = 1'b1;
        step(1);
        cs_n = 1'b1;
        step(6);
        chk("both_we_count", we_cnt - we0, 1);
        chk("both_waddr", last_wa, 9'd140);
        chk("both_no_fetch", fetch_cnt - f0, 0);
        chk("both_no_oe", oe_cnt - oe0, 0);

        // link timeout: 100 idle cycles after a doorbell
        rv0 = rvalid_cnt;
        xwrite(9'd127, 16'h0000);
        chk("wr_done_pulse", rvalid_cnt - rv0, 1);
        chk("timeout_low_after_db", link_timeout, 0);
        for (int i = 0; i < 300 && !link_timeout; i++) step(1);
        chk("timeout_asserted", link_timeout, 1);
        step(1);
        chk("timeout_length", to_cyc - db_cyc, 101);
        xwrite(9'd0, 16'h0000);
        chk("timeout_cleared", link_timeout, 0);

        // reset during R_HOLD with rd_n held low
        xaddr = 9'd44; cs_n = 1'b0;
        step(1);
        rd_n = 1'b0;
        wait_oe(lat, rdat);
        step(2);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_hold_oe", oe, 0);
        chk("rst_clears_wr_err", wr_err, 0);
        step(1);
        rst = 1'b0;
        f0 = fetch_cnt; oe0 = oe_cnt;
        step(10);
        chk("rst_held_rd_no_fetch", fetch_cnt - f0, 0);
        chk("rst_held_rd_no_oe", oe_cnt - oe0, 0);
        rd_n = 1'b1;
        step(4);
        rd_n = 1'b0;
        wait_oe(lat, rdat);
        chk("rearm_latency", lat, 5);
        chk("rearm_rdata", rdat, 16'h5A5A);
        step(3);
        rd_n = 1'b1;
        step(4);
        cs_n = 1'b1;
        step(4);

        chk("we_with_oe_or_no_en", viol_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
